rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Arbiter and sequencer for the register file's single write port in the pipelined MIPS core. It merges in-order writeback results with out-of-band results from multi-cycle units such as the divider and the load-miss return. Multi-cycle results are buffered in a small queue and drained into idle write-port cycles. If a queued result waits too long, the block stalls writeback for one slot. It resolves write-after-write (WAW) hazards and publishes a pending-register mask for the hazard unit.

## Interface
Parameters:
- DEPTH, 2: multi-cycle result queue entries; power of two, 2..8.
- AGE_MAX, 8: cycles the queue head may wait before writeback is forced to stall; range 2..255.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- wb_RegWrite  in  1  writeback stage requests a write this cycle.
- wb_Write_register  in  5  writeback destination register.
- wb_Write_data  in  32  writeback data.
- mc_valid  in  1  multi-cycle unit offers a result.
- mc_ready  out  1  queue can accept the offered result.
- mc_reg  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle result data.
- stall_wb  out  1  writeback stage must not write this cycle.
- RegWrite  out  1  write enable to the register file.
- Write_register  out  5  register file write address.
- Write_data  out  32  register file write data.
- pending_mask  out  32  bit r = 1 while any queued entry targets register r; bit 0 is always 0.

## Operation
- Port select, evaluated each cycle:
  - If wb_RegWrite=1 and wb_Write_register≠0, writeback wins.
  - Otherwise the queue head is dequeued and written, if one exists.
  - Otherwise no write occurs.
- Writeback writes to $0 count as idle cycles, so the queue head may use them.
- Enqueue:
  - mc_ready = !full.
  - A transfer happens when mc_valid & mc_ready.
  - A transfer with mc_reg=0 is accepted and discarded; nothing is enqueued.
- Enqueue and dequeue may occur in the same cycle, including when the queue is full; mc_ready still depends only on full, so this is never used to accept while full.
- WAW squash:
  - A winning writeback write to register r invalidates every queued entry whose register is r.
  - It also drops a same-cycle incoming transfer to r.
  - This rule relies on issue logic guaranteeing that multi-cycle results are older than the concurrent writeback instruction.
  - Squashed entries free their slots in the same cycle.
  - The head entry is never both squashed and written; writeback wins.
- Age and FSM:
  - The age counter increments while the queue head is valid and not dequeued.
  - It clears on dequeue and when the queue is empty.
  - IDLE (queue empty): go to WAIT when an entry is enqueued.
  - WAIT: go to FORCE when age = AGE_MAX-1 and the head is not dequeued. Go to IDLE when the queue becomes empty.
  - FORCE: stall_wb=1. The head is dequeued in this state's cycle, then go to WAIT if entries remain, else IDLE.
- stall_wb is a registered output equal to (state==FORCE).
- If writeback asserts wb_RegWrite during stall_wb anyway (protocol violation), writeback still wins and FORCE holds until the head is written.

## Timing
- RegWrite, Write_register and Write_data are registered, so the register file sees a write one cycle after selection.
- Writeback-to-register-file latency: 1 cycle.
- Queue latency: minimum 2 cycles from mc transfer to RegWrite (enqueue, then select, then register).
- Worst-case head wait: AGE_MAX+1 cycles.
- pending_mask is combinational from queue contents. An entry's bit clears in the cycle after it is selected, which is the same cycle its write reaches the register file.
- Reset values:
  - RegWrite=0, Write_register=0, Write_data=0.
  - stall_wb=0, mc_ready=1, pending_mask=0.
  - Queue empty, age=0, state=IDLE.
- Reset asserted mid-operation discards all queued entries; no partial write is emitted.

## Structure
- Shared package rf_arb_pkg holds:
  - DATA_W=32, REG_AW=5, REG_ZERO=5'd0.
  - State enum {IDLE, WAIT, FORCE}.
  - Entry struct {valid, reg, data}.
- Sub-module rf_wr_fifo: a DEPTH-entry in-order queue with per-entry valid bits, compaction or skip of squashed entries, a match-and-squash input (reg, enable), and full/empty/pending_mask outputs.
- The top level holds the port mux, output registers, age counter and FSM.

## Test plan
- Writeback only: wb writes $5=0x1234 → next cycle RegWrite=1, Write_register=5, Write_data=0x1234; mc_ready stays 1.
- Idle drain: mc $7=0xAA accepted with wb idle → RegWrite to $7=0xAA two cycles after the transfer; pending_mask[7] high for the intervening cycles.
- Full queue: wb writes continuously while mc offers 3 results with DEPTH=2 → mc_ready=0 after 2 transfers; the third waits.
- Forced stall: head queued while wb writes every cycle, AGE_MAX=8 → stall_wb=1 for exactly one cycle after the head has waited 8 cycles; head written next; stall_wb returns to 0.
- WAW squash: queue holds $9=0x1; wb writes $9=0x2 → only $9=0x2 is written; pending_mask[9] clears; the queue slot frees. Also check the mc_reg=0 transfer is discarded and the async reset mid-queue clears all state.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } rf_entry_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// In-order queue of multi-cycle results; slot 0 is always the head and
// squashed or popped entries are compacted out in the same cycle.
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [REG_AW-1:0] push_reg_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              squash_i,
    input  logic [REG_AW-1:0] squash_reg_i,
    output logic [REG_AW-1:0] head_reg_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              empty_next_o,
    output logic [31:0]       pending_mask_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    rf_entry_t        ent_q [DEPTH];
    rf_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] keep;
    logic [CW-1:0]    kept;

    // Survivors are packed toward slot 0 by rank; the push lands right after them.
    always_comb begin
        keep = '0;
        kept = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            ent_d[j] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            keep[i] = ent_q[i].valid
                      && !(pop_i && (i == 0))
                      && !(squash_i && (ent_q[i].rd == squash_reg_i));
            if (keep[i]) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (kept == CW'(j)) begin
                        ent_d[j] = ent_q[i];
                    end
                end
                kept = kept + 1'b1;
            end
        end
        if (push_i) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (kept == CW'(j)) begin
                    ent_d[j] = '{valid: 1'b1, rd: push_reg_i, data: push_data_i};
                end
            end
        end
    end

    always_comb begin
        pending_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                pending_mask_o[ent_q[i].rd] = 1'b1;
            end
        end
        pending_mask_o[0] = 1'b0;
    end

    assign head_reg_o   = ent_q[0].rd;
    assign head_data_o  = ent_q[0].data;
    assign empty_o      = !ent_q[0].valid;
    assign full_o       = ent_q[DEPTH-1].valid;
    assign empty_next_o = !ent_d[0].valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback wins, queued multi-cycle
// results drain into idle slots, and an aged head forces a one-slot stall.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned AGE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_Write_register,
    input  logic [DATA_W-1:0] wb_Write_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [REG_AW-1:0] mc_reg,
    input  logic [DATA_W-1:0] mc_data,
    output logic              stall_wb,
    output logic              RegWrite,
    output logic [REG_AW-1:0] Write_register,
    output logic [DATA_W-1:0] Write_data,
    output logic [31:0]       pending_mask
);

    localparam logic [7:0] AGE_LAST = 8'(AGE_MAX - 1);

    logic              wb_win;
    logic              deq;
    logic              push;
    logic              full;
    logic              empty;
    logic              empty_next;
    logic [REG_AW-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    arb_state_e        state_q, state_d;
    logic [7:0]        age_q, age_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    // Writes to $0 are treated as idle slots so the queue can use them.
    assign wb_win   = wb_RegWrite && (wb_Write_register != REG_ZERO);
    assign deq      = !wb_win && !empty;
    assign mc_ready = !full;
    assign push     = mc_valid && mc_ready && (mc_reg != REG_ZERO)
                      && !(wb_win && (mc_reg == wb_Write_register));

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (push),
        .push_reg_i     (mc_reg),
        .push_data_i    (mc_data),
        .pop_i          (deq),
        .squash_i       (wb_win),
        .squash_reg_i   (wb_Write_register),
        .head_reg_o     (head_reg),
        .head_data_o    (head_data),
        .full_o         (full),
        .empty_o        (empty),
        .empty_next_o   (empty_next),
        .pending_mask_o (pending_mask)
    );

    always_comb begin
        we_d = 1'b0;
        wa_d = '0;
        wd_d = '0;
        if (wb_win) begin
            we_d = 1'b1;
            wa_d = wb_Write_register;
            wd_d = wb_Write_data;
        end else if (deq) begin
            we_d = 1'b1;
            wa_d = head_reg;
            wd_d = head_data;
        end
    end

    // Saturates so a stall ignored by writeback cannot wrap the counter.
    always_comb begin
        age_d = age_q;
        if (empty || deq) begin
            age_d = '0;
        end else if (age_q != '1) begin
            age_d = age_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = WAIT;
            end
            WAIT: begin
                if (empty_next) state_d = IDLE;
                else if ((age_q == AGE_LAST) && !deq) state_d = FORCE;
            end
            FORCE: begin
                if (empty_next) state_d = IDLE;
                else if (deq) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            age_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    assign stall_wb       = (state_q == FORCE);
    assign RegWrite       = we_q;
    assign Write_register = wa_q;
    assign Write_data     = wd_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_RegWrite;
    logic [4:0]  wb_Write_register;
    logic [31:0] wb_Write_data;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    logic        stall_wb;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] pending_mask;

    int n_checks = 0;
    int n_errors = 0;

    rf_write_arbiter #(
        .DEPTH   (2),
        .AGE_MAX (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wb_RegWrite       (wb_RegWrite),
        .wb_Write_register (wb_Write_register),
        .wb_Write_data     (wb_Write_data),
        .mc_valid          (mc_valid),
        .mc_ready          (mc_ready),
        .mc_reg            (mc_reg),
        .mc_data           (mc_data),
        .stall_wb          (stall_wb),
        .RegWrite          (RegWrite),
        .Write_register    (Write_register),
        .Write_data        (Write_data),
        .pending_mask      (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
        chk({tag, ".we"}, 32'(RegWrite), 32'(en));
        if (en) begin
            chk({tag, ".wa"}, 32'(Write_register), 32'(r));
            chk({tag, ".wd"}, Write_data, d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_RegWrite = 1'b1; wb_Write_register = r; wb_Write_data = d;
    endtask

    task automatic wb_idle();
        wb_RegWrite = 1'b0; wb_Write_register = 5'd0; wb_Write_data = 32'd0;
    endtask

    task automatic mc(input logic [4:0] r, input logic [31:0] d);
        mc_valid = 1'b1; mc_reg = r; mc_data = d;
    endtask

    task automatic mc_idle();
        mc_valid = 1'b0; mc_reg = 5'd0; mc_data = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        wb_idle();
        mc_idle();
        #12;
        expect_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.wa", 32'(Write_register), 32'd0);
        chk("rst.wd", Write_data, 32'd0);
        chk("rst.stall", 32'(stall_wb), 32'd0);
        chk("rst.ready", 32'(mc_ready), 32'd1);
        chk("rst.mask", pending_mask, 32'd0);
        #11 reset = 1'b1;
        step();

        // writeback only
        wb(5'd5, 32'h1234);
        chk("wb.ready", 32'(mc_ready), 32'd1);
        step();
        wb_idle();
        expect_wr("wb", 1'b1, 5'd5, 32'h1234);
        chk("wb.ready2", 32'(mc_ready), 32'd1);
        step();
        expect_wr("wb.after", 1'b0, 5'd0, 32'd0);

        // idle drain
        mc(5'd7, 32'hAA);
        chk("drain.ready", 32'(mc_ready), 32'd1);
        step();
        mc_idle();
        chk("drain.mask", pending_mask, 32'h0000_0080);
        expect_wr("drain.sel", 1'b0, 5'd0, 32'd0);
        step();
        expect_wr("drain", 1'b1, 5'd7, 32'hAA);
        chk("drain.mask0", pending_mask, 32'd0);
        step();

        // full queue while writeback is busy
        wb(5'd1, 32'h101); mc(5'd10, 32'hD0A);
        chk("full.rdy_a", 32'(mc_ready), 32'd1);
        step();
        wb(5'd2, 32'h102); mc(5'd11, 32'hD0B);
        chk("full.rdy_b", 32'(mc_ready), 32'd1);
        expect_wr("full.b", 1'b1, 5'd1, 32'h101);
        step();
        wb(5'd3, 32'h103); mc(5'd12, 32'hD0C);
        chk("full.rdy_c", 32'(mc_ready), 32'd0);
        chk("full.mask_c", pending_mask, 32'h0000_0C00);
        expect_wr("full.c", 1'b1, 5'd2, 32'h102);
        step();
        wb_idle();
        chk("full.rdy_d", 32'(mc_ready), 32'd0);
        expect_wr("full.d", 1'b1, 5'd3, 32'h103);
        step();
        chk("full.rdy_e", 32'(mc_ready), 32'd1);
        expect_wr("full.e", 1'b1, 5'd10, 32'hD0A);
        step();
        mc_idle();
        expect_wr("full.f", 1'b1, 5'd11, 32'hD0B);
        chk("full.mask_f", pending_mask, 32'h0000_1000);
        step();
        expect_wr("full.g", 1'b1, 5'd12, 32'hD0C);
        chk("full.mask_g", pending_mask, 32'd0);
        chk("full.stall", 32'(stall_wb), 32'd0);
        step();

        // forced stall after the head waits AGE_MAX cycles
        wb(5'd1, 32'h200); mc(5'd20, 32'hD14);
        step();
        mc_idle();
        chk("age.mask", pending_mask, 32'h0010_0000);
        for (int i = 1; i <= 8; i++) begin
            wb(5'd1, 32'h200 + 32'(i));
            chk($sformatf("age.nostall%0d", i), 32'(stall_wb), 32'd0);
            step();
        end
        wb_idle();
        chk("age.stall", 32'(stall_wb), 32'd1);
        expect_wr("age.lastwb", 1'b1, 5'd1, 32'h208);
        step();
        chk("age.stall_off", 32'(stall_wb), 32'd0);
        expect_wr("age.head", 1'b1, 5'd20, 32'hD14);
        step();
        chk("age.stall_off2", 32'(stall_wb), 32'd0);
        expect_wr("age.after", 1'b0, 5'd0, 32'd0);

        // WAW squash of a queued entry
        wb(5'd3, 32'h33); mc(5'd9, 32'h1);
        step();
        mc_idle();
        chk("waw.mask", pending_mask, 32'h0000_0200);
        wb(5'd9, 32'h2);
        step();
        wb_idle();
        expect_wr("waw.wb", 1'b1, 5'd9, 32'h2);
        chk("waw.mask0", pending_mask, 32'd0);
        chk("waw.ready", 32'(mc_ready), 32'd1);
        step();
        expect_wr("waw.noold", 1'b0, 5'd0, 32'd0);
        chk("waw.stall", 32'(stall_wb), 32'd0);

        // WAW drop of a same-cycle incoming transfer
        wb(5'd9, 32'h3); mc(5'd9, 32'h4);
        step();
        wb_idle(); mc_idle();
        expect_wr("wawin.wb", 1'b1, 5'd9, 32'h3);
        chk("wawin.mask", pending_mask, 32'd0);
        step();
        expect_wr("wawin.none", 1'b0, 5'd0, 32'd0);

        // transfer to $0 is discarded
        mc(5'd0, 32'hFF);
        chk("zero.ready", 32'(mc_ready), 32'd1);
        step();
        mc_idle();
        chk("zero.mask", pending_mask, 32'd0);
        step();
        expect_wr("zero.none", 1'b0, 5'd0, 32'd0);

        // writeback to $0 is an idle slot for the queue head
        wb(5'd3, 32'h44); mc(5'd15, 32'hF);
        step();
        mc_idle();
        wb(5'd0, 32'hBAD);
        step();
        wb_idle();
        expect_wr("wb0.head", 1'b1, 5'd15, 32'hF);
        step();

        // async reset with a full queue
        wb(5'd1, 32'h301); mc(5'd21, 32'h21);
        step();
        wb(5'd2, 32'h302); mc(5'd22, 32'h22);
        step();
        chk("arst.pre_mask", pending_mask, 32'h0060_0000);
        chk("arst.pre_we", 32'(RegWrite), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst.mask", pending_mask, 32'd0);
        chk("arst.ready", 32'(mc_ready), 32'd1);
        chk("arst.we", 32'(RegWrite), 32'd0);
        chk("arst.wa", 32'(Write_register), 32'd0);
        chk("arst.stall", 32'(stall_wb), 32'd0);
        wb_idle(); mc_idle();
        #2 reset = 1'b1;
        step();
        expect_wr("arst.post1", 1'b0, 5'd0, 32'd0);
        chk("arst.post_mask", pending_mask, 32'd0);
        step();
        expect_wr("arst.post2", 1'b0, 5'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
